// File: rtl/fpu_pkg.sv
// Shared FP definitions for the FPU execute slice.
//   fop_t    : adder operation selector (add / subtract)
//   FADD_LAT : register stages inside the shared fadd instance
//   float_t  : IEEE-754 single-precision field view
//   flip_sign_if_sub : turns a subtract into an add on the second operand
package fpu_pkg;

  typedef enum logic {
    FOP_ADD = 1'b0,
    FOP_SUB = 1'b1
  } fop_t;

  localparam int FADD_LAT = 1;

  typedef struct packed {
    logic       s;
    logic [7:0] e;
    logic [22:0] f;
  } float_t;

  // a - b == a + (-b); negation of an IEEE value is a sign-bit flip,
  // including for zeros, infinities and NaNs.
  function automatic float_t flip_sign_if_sub(input float_t x, input fop_t op);
    float_t r;
    r   = x;
    r.s = x.s ^ (op == FOP_SUB);
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req    : request vector
//   ptr    : index with highest priority this cycle (owner keeps the register)
//   gnt    : one-hot grant, first requester at or above ptr, wrapping
//   gnt_id : binary index of the granted requester (0 when none)
//   any    : a grant was issued
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          any
);

  logic [IW-1:0] idx;

  always_comb begin
    // NOTE: every variable written here gets a default first, otherwise a
    // path that skips the assignment would infer a latch.
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = '0;
    // NOTE: blocking assignments in combinational logic so that 'any' set
    // by an earlier loop iteration is seen by the later ones.
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/fadd_arbiter.sv
// Shares one pipelined single-precision adder between N_REQ requesters.
//   clk, rst          : clock, synchronous active-high reset
//   flush             : drop every in-flight operation, no grant this cycle
//   req_valid/ready   : per-requester handshake, ready is a one-hot grant
//   req_op            : per-requester 0 = add, 1 = sub
//   req_x1/req_x2     : per-requester operands, packed 32 bits each
//   req_tag           : per-requester tag, returned with the result
//   resp_valid        : one-cycle pulse to the requester that owns resp_y
//   resp_y, resp_tag  : result and its tag, shared by all requesters
//   busy              : any operation still in flight
//   fa_x1/fa_x2/fa_y  : connection to the external fadd instance
module fadd_arbiter
  import fpu_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int LAT   = FADD_LAT,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ-1:0]       req_op,
  input  logic [N_REQ*32-1:0]    req_x1,
  input  logic [N_REQ*32-1:0]    req_x2,
  input  logic [N_REQ*TAG_W-1:0] req_tag,
  output logic [N_REQ-1:0]       resp_valid,
  output logic [31:0]            resp_y,
  output logic [TAG_W-1:0]       resp_tag,
  output logic                   busy,
  output logic [31:0]            fa_x1,
  output logic [31:0]            fa_x2,
  input  logic [31:0]            fa_y
);

  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0] req_eff;
  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    gnt_id;
  logic             gnt_any;
  logic [IW-1:0]    ptr;
  logic [TAG_W-1:0] gnt_tag;
  float_t           x2_sel;

  // Tag pipeline: valid bits run one stage past the adder so busy covers
  // the cycle in which the result is being registered.
  logic [LAT:0]     stg_v;
  logic [IW-1:0]    stg_id  [LAT];
  logic [TAG_W-1:0] stg_tag [LAT];

  // Masking the requests (not the grant) keeps ptr and the tag pipeline
  // consistent: no grant means nothing is accepted and ptr holds.
  assign req_eff = (rst || flush) ? '0 : req_valid;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr_arbiter (
    .req    (req_eff),
    .ptr    (ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (gnt_any)
  );

  assign req_ready = gnt;

  always_comb begin
    fa_x1   = '0;
    x2_sel  = '0;
    gnt_tag = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        fa_x1   = req_x1[i*32 +: 32];
        x2_sel  = flip_sign_if_sub(float_t'(req_x2[i*32 +: 32]), fop_t'(req_op[i]));
        gnt_tag = req_tag[i*TAG_W +: TAG_W];
      end
    end
    fa_x2 = x2_sel;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      stg_v      <= '0;
      resp_valid <= '0;
      resp_y     <= '0;
      resp_tag   <= '0;
    end else begin
      if (gnt_any) begin
        ptr <= (gnt_id == IW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
      end
      stg_v      <= flush ? '0 : {stg_v[LAT-1:0], gnt_any};
      resp_valid <= '0;
      if (stg_v[LAT-1] && !flush) begin
        resp_valid[stg_id[LAT-1]] <= 1'b1;
        resp_y                    <= fa_y;
        resp_tag                  <= stg_tag[LAT-1];
      end
    end
  end

  // NOTE: id/tag payload has no reset; it is only ever consumed under its
  // valid bit, which is reset, so leaving it unreset is safe and cheaper.
  always_ff @(posedge clk) begin
    stg_id[0]  <= gnt_id;
    stg_tag[0] <= gnt_tag;
    for (int k = 1; k < LAT; k++) begin
      stg_id[k]  <= stg_id[k-1];
      stg_tag[k] <= stg_tag[k-1];
    end
  end

  assign busy = (|stg_v) || (|resp_valid);

endmodule

// File: tb/tb_fadd_arbiter.sv
// Self-checking bench for fadd_arbiter with a behavioural 1-stage fadd.
// Stimulus pushes hand-computed expected responses into a scoreboard at
// acceptance time; a monitor pops and compares on every resp_valid.
module tb_fadd_arbiter;

  localparam logic [31:0] F1 = 32'h3F80_0000;  // 1.0
  localparam logic [31:0] F2 = 32'h4000_0000;  // 2.0
  localparam logic [31:0] F3 = 32'h4040_0000;  // 3.0
  localparam logic [31:0] F4 = 32'h4080_0000;  // 4.0
  localparam logic [31:0] F6 = 32'h40C0_0000;  // 6.0
  localparam logic [31:0] NEG_F1 = 32'hBF80_0000;  // -1.0

  logic        clk;
  logic        rst;
  logic        flush;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_op;
  logic [63:0] req_x1;
  logic [63:0] req_x2;
  logic [7:0]  req_tag;
  logic [1:0]  resp_valid;
  logic [31:0] resp_y;
  logic [3:0]  resp_tag;
  logic        busy;
  logic [31:0] fa_x1;
  logic [31:0] fa_x2;
  logic [31:0] fa_y;

  fadd_arbiter #(.N_REQ(2), .LAT(1), .TAG_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_x1     (req_x1),
    .req_x2     (req_x2),
    .req_tag    (req_tag),
    .resp_valid (resp_valid),
    .resp_y     (resp_y),
    .resp_tag   (resp_tag),
    .busy       (busy),
    .fa_x1      (fa_x1),
    .fa_x2      (fa_x2),
    .fa_y       (fa_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural fadd: single -> double, add, double -> single (truncating;
  // every test value here is exactly representable).
  function automatic real sp2r(input logic [31:0] b);
    logic [10:0] e;
    if (b[30:23] == 8'd0) return $bitstoreal({b[31], 63'd0});
    e = {3'd0, b[30:23]} + 11'd896;
    return $bitstoreal({b[31], e, b[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  always @(posedge clk) fa_y <= r2sp(sp2r(fa_x1) + sp2r(fa_x2));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    logic [31:0] y;
    logic [3:0]  tag;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response must match the oldest expected entry exactly,
  // including the cycle in which it appears.
  exp_t e;
  always @(negedge clk) begin
    if (resp_valid != 2'b00) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_resp: got valid=%b y=%h tag=%h expected no response (cycle %0d)",
                 resp_valid, resp_y, resp_tag, cyc);
      end else begin
        e = sb.pop_front();
        if (resp_valid != (2'b01 << e.id) || resp_y !== e.y || resp_tag !== e.tag || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL resp: got valid=%b y=%h tag=%h cycle=%0d expected valid=%b y=%h tag=%h cycle=%0d",
                   resp_valid, resp_y, resp_tag, cyc, 2'b01 << e.id, e.y, e.tag, e.cyc);
        end
      end
    end
  end

  task automatic set_req(input int i, input logic v, input logic op,
                         input logic [31:0] x1, input logic [31:0] x2, input logic [3:0] tag);
    req_valid[i]          = v;
    req_op[i]             = op;
    req_x1[i*32 +: 32]    = x1;
    req_x2[i*32 +: 32]    = x2;
    req_tag[i*4 +: 4]     = tag;
  endtask

  task automatic clear_reqs();
    req_valid = 2'b00;
    req_op    = 2'b00;
  endtask

  // Checks the grant mid-cycle; when push is set the transfer's expected
  // response (owner taken from the expected grant) is queued for cycle+2.
  task automatic sample(input logic [1:0] exp_ready, input bit push,
                        input logic [31:0] y, input logic [3:0] tag);
    @(negedge clk);
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    if (push && exp_ready != 2'b00)
      sb.push_back('{id: (exp_ready[1] ? 1 : 0), y: y, tag: tag, cyc: cyc + 2});
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic [1:0] exp_ready, input bit push,
                      input logic [31:0] y, input logic [3:0] tag);
    sample(exp_ready, push, y, tag);
    advance();
  endtask

  task automatic idle(input int n);
    clear_reqs();
    for (int k = 0; k < n; k++) tick(2'b00, 1'b0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    req_x1    = '0;
    req_x2    = '0;
    req_tag   = '0;
    req_op    = '0;
    req_valid = 2'b11;

    // Reset state: no grant even with both requesting, outputs cleared.
    advance();
    sample(2'b00, 1'b0, '0, '0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_y", resp_y, 32'd0);
    check("rst_resp_tag", 32'(resp_tag), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    advance();
    rst = 1'b0;

    // Contention from reset: grants 0,1,0,1, results back to back.
    set_req(0, 1, 0, F1, F1, 4'd1);
    set_req(1, 1, 0, F2, F2, 4'd2);
    tick(2'b01, 1'b1, F2, 4'd1);
    set_req(0, 1, 0, F1, F2, 4'd3);
    tick(2'b10, 1'b1, F4, 4'd2);
    set_req(1, 1, 0, F2, F4, 4'd4);
    tick(2'b01, 1'b1, F3, 4'd3);
    tick(2'b10, 1'b1, F6, 4'd4);
    idle(3);

    // Single add on requester 0.
    set_req(0, 1, 0, F1, F2, 4'd5);
    tick(2'b01, 1'b1, F3, 4'd5);
    idle(3);
    sample(2'b00, 1'b0, '0, '0);
    check("busy_after_add", 32'(busy), 32'd0);
    advance();

    // Subtract on requester 1: second operand sign flipped toward the adder.
    set_req(1, 1, 1, F3, F1, 4'd6);
    sample(2'b10, 1'b1, F2, 4'd6);
    check("sub_fa_x1", fa_x1, F3);
    check("sub_fa_x2", fa_x2, NEG_F1);
    advance();
    idle(3);

    // Throughput: 8 back-to-back accepts from requester 0 alone.
    for (int k = 0; k < 8; k++) begin
      set_req(0, 1, 0, F1, F1, 4'(k));
      tick(2'b01, 1'b1, F2, 4'(k));
    end
    clear_reqs();
    sample(2'b00, 1'b0, '0, '0);
    check("tp_busy_t1", 32'(busy), 32'd1);
    advance();
    sample(2'b00, 1'b0, '0, '0);
    check("tp_busy_t2", 32'(busy), 32'd1);
    advance();
    sample(2'b00, 1'b0, '0, '0);
    check("tp_busy_t3", 32'(busy), 32'd0);
    advance();

    // Flush one cycle after an accept: that result is dropped, the next
    // request completes normally.
    set_req(0, 1, 0, F1, F1, 4'd9);
    tick(2'b01, 1'b0, '0, '0);
    flush = 1'b1;
    tick(2'b00, 1'b0, '0, '0);
    flush = 1'b0;
    set_req(0, 1, 0, F1, F2, 4'd10);
    tick(2'b01, 1'b1, F3, 4'd10);
    idle(4);

    // Reset mid-operation: ptr is 1 here. The first op reaches the response
    // register in the reset cycle itself; the second is never delivered.
    set_req(1, 1, 0, F1, F1, 4'd11);
    tick(2'b10, 1'b1, F2, 4'd11);
    req_valid[1] = 1'b0;
    set_req(0, 1, 0, F2, F2, 4'd12);
    tick(2'b01, 1'b0, '0, '0);
    rst = 1'b1;
    req_valid = 2'b11;
    tick(2'b00, 1'b0, '0, '0);
    rst = 1'b0;
    clear_reqs();
    sample(2'b00, 1'b0, '0, '0);
    check("post_rst_resp_valid", 32'(resp_valid), 32'd0);
    check("post_rst_resp_y", resp_y, 32'd0);
    check("post_rst_resp_tag", 32'(resp_tag), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    advance();
    // ptr restarted at 0: requester 0 wins against requester 1.
    set_req(0, 1, 0, F2, F2, 4'd13);
    set_req(1, 1, 0, F1, F1, 4'd14);
    tick(2'b01, 1'b1, F4, 4'd13);
    idle(4);

    sample(2'b00, 1'b0, '0, '0);
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
